// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder slice plus a carry flop, LSB first.
// Start/busy/done handshake; results and flags are registered and held until the next completion.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Data_in_Start,
    input  logic             Data_in_Sub,
    input  logic [WIDTH-1:0] Data_in_A,
    input  logic [WIDTH-1:0] Data_in_B,
    input  logic             Data_in_C,
    output logic [WIDTH-1:0] Data_out_Sum,
    output logic             Data_out_Carry,
    output logic             Data_out_Overflow,
    output logic             Data_out_Busy,
    output logic             Data_out_Done
);

    localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int ACC_W = WIDTH - 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic              c_reg, c_next;
    logic [WIDTH-1:0]  ra_reg, ra_next;
    logic [WIDTH-1:0]  rb_reg, rb_next;
    logic [ACC_W-1:0]  acc_reg, acc_next;
    logic [WIDTH-1:0]  sum_reg, sum_next;
    logic              carry_reg, carry_next;
    logic              ovf_reg, ovf_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;

    logic [WIDTH-1:0]  b_load;
    logic              s_bit;
    logic              c_out;
    logic              last_bit;

    // Subtraction is A + ~B + ~C, so B is inverted on load and the borrow folds into the carry flop.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_b_load
            assign b_load[gi] = Data_in_B[gi] ^ Data_in_Sub;
        end
    endgenerate

    assign s_bit    = ra_reg[0] ^ rb_reg[0] ^ c_reg;
    assign c_out    = (ra_reg[0] & rb_reg[0]) | (c_reg & (ra_reg[0] ^ rb_reg[0]));
    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        c_next     = c_reg;
        ra_next    = ra_reg;
        rb_next    = rb_reg;
        acc_next   = acc_reg;
        sum_next   = sum_reg;
        carry_next = carry_reg;
        ovf_next   = ovf_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (Data_in_Start) begin
                    ra_next    = Data_in_A;
                    rb_next    = b_load;
                    c_next     = Data_in_C ^ Data_in_Sub;
                    cnt_next   = '0;
                    busy_next  = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                c_next   = c_out;
                ra_next  = ra_reg >> 1;
                rb_next  = rb_reg >> 1;
                // acc holds the WIDTH-1 low sum bits; the final bit joins it directly at completion.
                acc_next = ACC_W'({s_bit, acc_reg} >> 1);
                cnt_next = cnt_reg + CW'(1);
                if (last_bit) begin
                    sum_next   = {s_bit, acc_reg};
                    carry_next = c_out;
                    ovf_next   = c_reg ^ c_out;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            c_reg     <= 1'b0;
            ra_reg    <= '0;
            rb_reg    <= '0;
            acc_reg   <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            c_reg     <= c_next;
            ra_reg    <= ra_next;
            rb_reg    <= rb_next;
            acc_reg   <= acc_next;
            sum_reg   <= sum_next;
            carry_reg <= carry_next;
            ovf_reg   <= ovf_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign Data_out_Sum      = sum_reg;
    assign Data_out_Carry    = carry_reg;
    assign Data_out_Overflow = ovf_reg;
    assign Data_out_Busy     = busy_reg;
    assign Data_out_Done     = done_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vector table, handshake corner cases,
// random WIDTH=8 operations and an exhaustive WIDTH=2 sweep against an arithmetic model.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rst2;
    logic       start8, sub8, c8;
    logic [7:0] a8, b8, sum8;
    logic       carry8, ovf8, busy8, done8;
    logic       start2, sub2, c2;
    logic [1:0] a2, b2, sum2;
    logic       carry2, ovf2, busy2, done2;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .Data_in_Start(start8), .Data_in_Sub(sub8),
        .Data_in_A(a8), .Data_in_B(b8), .Data_in_C(c8),
        .Data_out_Sum(sum8), .Data_out_Carry(carry8), .Data_out_Overflow(ovf8),
        .Data_out_Busy(busy8), .Data_out_Done(done8)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst2),
        .Data_in_Start(start2), .Data_in_Sub(sub2),
        .Data_in_A(a2), .Data_in_B(b2), .Data_in_C(c2),
        .Data_out_Sum(sum2), .Data_out_Carry(carry2), .Data_out_Overflow(ovf2),
        .Data_out_Busy(busy2), .Data_out_Done(done2)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        bit         c;
        bit         sub;
        logic [7:0] s;
        bit         co;
        bit         ov;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic modulo 2^w, signed range test for overflow.
    function automatic void model(input int w, input longint a, input longint b, input longint c,
                                  input longint sub, output longint s, output longint co,
                                  output longint ov);
        longint mask, tot, half, sa, sb, r;
        mask = (64'sd1 <<< w) - 1;
        half = 64'sd1 <<< (w - 1);
        if (sub == 0) tot = a + b + c;
        else          tot = a + ((~b) & mask) + (1 - c);
        s  = tot & mask;
        co = (tot >>> w) & 1;
        sa = (a >= half) ? a - 2 * half : a;
        sb = (b >= half) ? b - 2 * half : b;
        r  = (sub == 0) ? sa + sb + c : sa - sb - c;
        ov = ((r < -half) || (r > half - 1)) ? 1 : 0;
    endfunction

    function automatic logic busy_of(input int w);
        return (w == 8) ? busy8 : busy2;
    endfunction

    function automatic logic done_of(input int w);
        return (w == 8) ? done8 : done2;
    endfunction

    // Called #1 after a start edge; counts edges until Done (bounded), -1 on timeout.
    task automatic wait_done(input int w, output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = busy_of(w) ? 1 : 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (done_of(w)) break;
            if (busy_of(w)) busy_cnt++;
        end
        if (!done_of(w)) lat = -1;
    endtask

    task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b, input bit c,
                          input bit sub, output logic [7:0] s, output bit co, output bit ov,
                          output int lat, output int busy_cnt);
        @(negedge clk);
        if (w == 8) begin
            a8 = a; b8 = b; c8 = c; sub8 = sub; start8 = 1'b1;
        end else begin
            a2 = a[1:0]; b2 = b[1:0]; c2 = c; sub2 = sub; start2 = 1'b1;
        end
        @(posedge clk);
        #1;
        start8 = 1'b0;
        start2 = 1'b0;
        // operands may change freely once accepted
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom); sub8 = 1'($urandom);
        a2 = 2'($urandom); b2 = 2'($urandom); c2 = 1'($urandom); sub2 = 1'($urandom);
        wait_done(w, lat, busy_cnt);
        s  = (w == 8) ? sum8 : {6'b0, sum2};
        co = (w == 8) ? carry8 : carry2;
        ov = (w == 8) ? ovf8 : ovf2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s;
        bit         co, ov;
        int         lat, bc, done_seen;
        longint     es, ec, eo;
        logic [7:0] ra, rb;
        bit         rc, rs;

        vecs[0] = '{8'h5A, 8'h25, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{8'h05, 8'h02, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0};

        rst = 1'b1; rst2 = 1'b1;
        start8 = 0; sub8 = 0; c8 = 0; a8 = '0; b8 = '0;
        start2 = 0; sub2 = 0; c2 = 0; a2 = '0; b2 = '0;
        #1;
        chk("reset_sum8", sum8, 0);
        chk("reset_flags8", {carry8, ovf8, busy8, done8}, 0);
        chk("reset_out2", {sum2, carry2, ovf2, busy2, done2}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; rst2 = 1'b0;

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            run_op(8, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].sub, s, co, ov, lat, bc);
            chk($sformatf("vec%0d_sum", i), s, vecs[i].s);
            chk($sformatf("vec%0d_carry", i), co, vecs[i].co);
            chk($sformatf("vec%0d_ovf", i), ov, vecs[i].ov);
            chk($sformatf("vec%0d_latency", i), lat, 8);
            chk($sformatf("vec%0d_busy_cycles", i), bc, 8);
            chk($sformatf("vec%0d_busy_at_done", i), busy8, 0);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_done_pulse", i), done8, 0);
        end

        // Start re-pulsed mid-operation is ignored
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h25; c8 = 0; sub8 = 0; start8 = 1;
        @(posedge clk);
        #1;
        start8 = 0;
        repeat (3) @(posedge clk);
        #1;
        a8 = 8'h01; b8 = 8'h01; c8 = 1; sub8 = 1; start8 = 1;
        @(posedge clk);
        #1;
        start8 = 0;
        wait_done(8, lat, bc);
        chk("restart_latency", lat + 4, 8);
        chk("restart_sum", sum8, 8'h7F);
        chk("restart_carry", carry8, 0);
        done_seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            done_seen += done8 ? 1 : 0;
        end
        chk("restart_no_second_done", done_seen, 0);

        // Back-to-back: start held during the Done cycle
        run_op(8, 8'h11, 8'h22, 1'b0, 1'b0, s, co, ov, lat, bc);
        chk("b2b_first_sum", s, 8'h33);
        chk("b2b_first_latency", lat, 8);
        a8 = 8'hC0; b8 = 8'h50; c8 = 1; sub8 = 0; start8 = 1;
        @(posedge clk);
        #1;
        start8 = 0;
        chk("b2b_busy_no_gap", busy8, 1);
        chk("b2b_done_dropped", done8, 0);
        wait_done(8, lat, bc);
        chk("b2b_second_latency", lat, 8);
        chk("b2b_second_sum", sum8, 8'h11);
        chk("b2b_second_carry", carry8, 1);
        chk("b2b_second_ovf", ovf8, 0);

        // Asynchronous reset while bit 4 is in flight
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h25; c8 = 0; sub8 = 0; start8 = 1;
        @(posedge clk);
        #1;
        start8 = 0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("abort_outputs_async", {sum8, carry8, ovf8, busy8, done8}, 0);
        @(posedge clk);
        #1;
        chk("abort_outputs_held", {sum8, carry8, ovf8, busy8, done8}, 0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            done_seen += done8 ? 1 : 0;
        end
        chk("abort_no_done", done_seen, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_op(8, 8'h80, 8'h80, 1'b1, 1'b0, s, co, ov, lat, bc);
        chk("after_reset_sum", s, 8'h01);
        chk("after_reset_flags", {co, ov}, 2'b11);
        chk("after_reset_latency", lat, 8);

        // Random WIDTH=8 operations against the model
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            model(8, ra, rb, rc, rs, es, ec, eo);
            run_op(8, ra, rb, rc, rs, s, co, ov, lat, bc);
            chk($sformatf("rand%0d_sum a=%0h b=%0h c=%0d sub=%0d", i, ra, rb, rc, rs), s, es);
            chk($sformatf("rand%0d_carry", i), co, ec);
            chk($sformatf("rand%0d_ovf", i), ov, eo);
            chk($sformatf("rand%0d_latency", i), lat, 8);
        end

        // Exhaustive WIDTH=2 sweep
        for (int sb = 0; sb < 2; sb++) begin
            for (int cc = 0; cc < 2; cc++) begin
                for (int aa = 0; aa < 4; aa++) begin
                    for (int bb = 0; bb < 4; bb++) begin
                        model(2, aa, bb, cc, sb, es, ec, eo);
                        run_op(2, 8'(aa), 8'(bb), 1'(cc), 1'(sb), s, co, ov, lat, bc);
                        chk($sformatf("w2_sum a=%0d b=%0d c=%0d sub=%0d", aa, bb, cc, sb), s, es);
                        chk($sformatf("w2_carry a=%0d b=%0d c=%0d sub=%0d", aa, bb, cc, sb), co, ec);
                        chk($sformatf("w2_ovf a=%0d b=%0d c=%0d sub=%0d", aa, bb, cc, sb), ov, eo);
                        chk($sformatf("w2_latency a=%0d b=%0d c=%0d sub=%0d", aa, bb, cc, sb), lat, 2);
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor. It is the sequential successor to the single-bit full adder: one full-adder slice plus a carry flip-flop processes one operand bit per clock, LSB first. It accepts two WIDTH-bit operands and a carry-in with a start/busy/done handshake, and returns a WIDTH-bit result with carry and signed overflow. It trades area for latency in the arithmetic datapath.

## Interface
Parameters:
- WIDTH, default 8: operand and result width in bits; legal range is WIDTH >= 2.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- Data_in_Start  input  1  request a new operation; sampled only in IDLE.
- Data_in_Sub  input  1  operation select: 0 = A+B+C, 1 = A-B-C (C acts as borrow-in).
- Data_in_A  input  WIDTH  first operand.
- Data_in_B  input  WIDTH  second operand.
- Data_in_C  input  1  carry-in (add) or borrow-in (subtract).
- Data_out_Sum  output  WIDTH  registered result.
- Data_out_Carry  output  1  carry-out. When subtracting, 1 means no borrow.
- Data_out_Overflow  output  1  two's-complement overflow of the result.
- Data_out_Busy  output  1  operation in progress.
- Data_out_Done  output  1  one-cycle pulse marking result valid.

## Operation
States:
- IDLE
  - Data_out_Busy = 0.
  - Data_in_Start = 1 at an edge: latch A into shift register ra; latch B into rb (B inverted when Sub = 1); load carry flop c = Data_in_C ^ Data_in_Sub; clear the bit counter; go to RUN.
- RUN
  - Data_out_Busy = 1.
  - Each edge:
    - s = ra[0]^rb[0]^c
    - c <= ra[0]&rb[0] | c&(ra[0]^rb[0])
    - ra and rb shift right by one bit.
    - s shifts into the MSB of the internal sum register.
    - counter increments.
  - On the edge processing bit WIDTH-1:
    - Data_out_Sum <= completed sum register.
    - Data_out_Carry <= carry out of bit WIDTH-1.
    - Data_out_Overflow <= carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
    - Data_out_Done <= 1.
    - Go to IDLE.

Rules:
- Data_in_Start is ignored while Busy = 1. Operand inputs may change freely after the start edge.
- Result outputs update only at completion and hold until the next completion.
- Data_out_Done is high for exactly one cycle per completed operation.
- Start asserted during the Done cycle is accepted at that edge, because the block is already in IDLE. This gives back-to-back operation with no gap.
- Arithmetic is modulo 2^WIDTH.
  - Carry is bit WIDTH of A + B + C (add) or of A + ~B + ~C (subtract).
  - Overflow follows the standard signed rule.
- Reset (rst = 1), at any time including mid-operation:
  - All of the following go to 0 immediately: state IDLE, counter, carry flop, shift registers, Data_out_Sum, Data_out_Carry, Data_out_Overflow, Data_out_Busy, Data_out_Done.
  - An aborted operation never produces Done.
- Counter width is $clog2(WIDTH). The counter never wraps during a legal operation.

## Timing
- Start sampled high at edge k:
  - Busy = 1 after edge k.
  - Bits 0..WIDTH-1 are processed at edges k+1..k+WIDTH.
  - After edge k+WIDTH: Busy = 0, Done = 1, and results are valid.
  - Done returns to 0 after edge k+WIDTH+1 unless a new operation completes.
- Latency: WIDTH cycles from the start edge to Done.
- Throughput: one operation per WIDTH cycles.
- All outputs are driven directly from flops. There are no combinational paths from inputs to outputs.

## Test plan
WIDTH = 8 unless stated otherwise.
- A=0x5A, B=0x25, C=0, Sub=0 -> Sum=0x7F, Carry=0, Overflow=0; Done exactly 8 cycles after the start edge, Busy high for those 8 cycles.
- A=0xFF, B=0x01, C=0, Sub=0 -> Sum=0x00, Carry=1, Overflow=0. A=0x7F, B=0x00, C=1 -> Sum=0x80, Carry=0, Overflow=1.
- Subtract: A=0x10, B=0x20, C=0 -> Sum=0xF0, Carry=0, Overflow=0. A=0x80, B=0x01, C=0 -> Sum=0x7F, Carry=1, Overflow=1. A=0x05, B=0x02, C=1 -> Sum=0x02, Carry=1.
- Start re-pulsed mid-operation with different operands -> ignored, first result unchanged. Start held during the Done cycle -> second operation accepted with no gap, second Done 8 cycles later.
- rst asserted asynchronously while bit 4 is being processed -> Busy, Done and all outputs at 0 immediately, no Done for the aborted operation. A start 1 cycle after release completes correctly.
- WIDTH=2 -> exhaustive sweep of all 64 combinations of A, B, C and Sub against a reference model; every result completes in 2 cycles.
